y86_decode_pipe: RTL and testbench

Parametrised decode stage for the pipelined Y86-64 processor. It replaces the SEQ decode and register-file logic with the following features:
- a register file of configurable width and depth;
- two write-back ports (E and M) with same-cycle read bypass;
- a registered D/E pipeline register with stall and bubble control.

It sits between fetch (F/D outputs) and execute, and owns all architectural general-purpose registers.

---
 rtl/y86_decode_pipe.sv | 159 +++++++++++++++
 tb/tb_y86_decode_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_decode_pipe.sv
// Y86-64 pipelined decode stage: register file with two write-back ports,
// same-cycle read bypass, and the D/E pipeline register with stall/bubble.
module y86_decode_pipe #(
    parameter int                 DATA_W   = 64,
    parameter int                 NREG     = 15,
    parameter int                 RSP_ID   = 4,
    parameter logic [DATA_W-1:0]  RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic              D_valid,
    input  logic              E_stall,
    input  logic              E_bubble,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic              E_valid,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP4  = 4'(RSP_ID);
    localparam logic [4:0] NREG5 = 5'(NREG);

    logic [DATA_W-1:0] r_regs [NREG];

    logic [3:0]        w_srcA, w_srcB, w_dstE, w_dstM;
    logic [DATA_W-1:0] w_arrA, w_arrB, w_rdA, w_rdB, w_valA;

    logic [3:0]        r_icode, r_ifun, r_srcA, r_srcB, r_dstE, r_dstM;
    logic [DATA_W-1:0] r_valC, r_valA, r_valB;
    logic              r_valid;

    // Port M has priority over port E so a read sees the value that will win the write.
    function automatic logic [DATA_W-1:0] f_bypass(
        input logic [3:0]        id,
        input logic [DATA_W-1:0] arr,
        input logic [3:0]        dst_m,
        input logic [DATA_W-1:0] val_m,
        input logic [3:0]        dst_e,
        input logic [DATA_W-1:0] val_e
    );
        if (id == RNONE || {1'b0, id} >= NREG5)
            return '0;
        else if (id == dst_m)
            return val_m;
        else if (id == dst_e)
            return val_e;
        else
            return arr;
    endfunction

    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (D_icode)
            4'h2, 4'h4, 4'h6, 4'hA: w_srcA = D_rA;
            4'h9, 4'hB:             w_srcA = RSP4;
            default:                ;
        endcase
        case (D_icode)
            4'h4, 4'h5, 4'h6:       w_srcB = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_srcB = RSP4;
            default:                ;
        endcase
        // cmovXX writes rB unconditionally here; execute squashes it if the condition fails.
        case (D_icode)
            4'h2, 4'h3, 4'h6:       w_dstE = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_dstE = RSP4;
            default:                ;
        endcase
        case (D_icode)
            4'h5, 4'hB:             w_dstM = D_rA;
            default:                ;
        endcase
    end

    always_comb begin
        w_arrA = ({1'b0, w_srcA} < NREG5) ? r_regs[w_srcA] : '0;
        w_arrB = ({1'b0, w_srcB} < NREG5) ? r_regs[w_srcB] : '0;
        w_rdA  = f_bypass(w_srcA, w_arrA, W_dstM, W_valM, W_dstE, W_valE);
        w_rdB  = f_bypass(w_srcB, w_arrB, W_dstM, W_valM, W_dstE, W_valE);
        w_valA = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : w_rdA;
    end

    assign dbg_data = ({1'b0, dbg_sel} < NREG5) ? r_regs[dbg_sel] : '0;

    // Write-back ignores stall/bubble; the M port overrides E on a shared target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= (i == RSP_ID) ? RSP_INIT : '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (W_dstM == 4'(i))
                    r_regs[i] <= W_valM;
                else if (W_dstE == 4'(i))
                    r_regs[i] <= W_valE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || E_bubble || (!E_stall && !D_valid)) begin
            r_icode <= 4'h1;
            r_ifun  <= 4'h0;
            r_valC  <= '0;
            r_valA  <= '0;
            r_valB  <= '0;
            r_srcA  <= RNONE;
            r_srcB  <= RNONE;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_valid <= 1'b0;
        end else if (!E_stall) begin
            r_icode <= D_icode;
            r_ifun  <= D_ifun;
            r_valC  <= D_valC;
            r_valA  <= w_valA;
            r_valB  <= w_rdB;
            r_srcA  <= w_srcA;
            r_srcB  <= w_srcB;
            r_dstE  <= w_dstE;
            r_dstM  <= w_dstM;
            r_valid <= 1'b1;
        end
    end

    assign E_icode = r_icode;
    assign E_ifun  = r_ifun;
    assign E_valC  = r_valC;
    assign E_valA  = r_valA;
    assign E_valB  = r_valB;
    assign E_srcA  = r_srcA;
    assign E_srcB  = r_srcB;
    assign E_dstE  = r_dstE;
    assign E_dstM  = r_dstM;
    assign E_valid = r_valid;

endmodule

// File: tb/tb_y86_decode_pipe.sv
// Bench for y86_decode_pipe: directed test-plan cases plus random traffic,
// scored against an abstract register-file/pipeline model.
module tb_y86_decode_pipe;

    localparam int          NREG     = 15;
    localparam logic [63:0] RSP_INIT = 64'h100;
    localparam logic [3:0]  RN       = 4'hF;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic        valid;
    } e_t;

    logic        clk, rst;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        D_valid, E_stall, E_bubble;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        E_valid;
    logic [3:0]  dbg_sel;
    logic [63:0] dbg_data;

    y86_decode_pipe #(.DATA_W(64), .NREG(NREG), .RSP_ID(4), .RSP_INIT(RSP_INIT)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_valid(D_valid),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
        .E_valB(E_valB), .E_srcA(E_srcA), .E_srcB(E_srcB), .E_dstE(E_dstE),
        .E_dstM(E_dstM), .E_valid(E_valid),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    e_t   exp_q[$];
    logic [63:0] m_regs [16];
    e_t   m_e;

    function automatic e_t bubble_val();
        e_t b;
        b.icode = 4'h1; b.ifun = 4'h0;
        b.valC = '0; b.valA = '0; b.valB = '0;
        b.srcA = RN; b.srcB = RN; b.dstE = RN; b.dstM = RN;
        b.valid = 1'b0;
        return b;
    endfunction

    function automatic e_t dut_e();
        return {E_icode, E_ifun, E_valC, E_valA, E_valB, E_srcA, E_srcB, E_dstE, E_dstM, E_valid};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = (i == 4) ? RSP_INIT : 64'd0;
        m_e = bubble_val();
    endfunction

    function automatic bit reg_ok(input logic [3:0] id);
        return id != RN && int'(id) < NREG;
    endfunction

    // Value a decode read of id sees this cycle, given the write-back inputs now on the bus.
    function automatic logic [63:0] m_read(input logic [3:0] id, input logic [3:0] de,
                                           input logic [63:0] ve, input logic [3:0] dm,
                                           input logic [63:0] vm);
        if (!reg_ok(id)) return 64'd0;
        if (id == dm) return vm;
        if (id == de) return ve;
        return m_regs[id];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_dbg(input logic [3:0] sel);
        logic [63:0] e;
        e = reg_ok(sel) ? m_regs[sel] : 64'd0;
        dbg_sel = sel;
        #1;
        chk($sformatf("dbg_data[%0d]", sel), dbg_data, e);
    endtask

    // driver: one D-stage cycle; returns 1ns after the capturing edge
    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                         input logic vld, input logic st, input logic bb,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        e_t nx;
        logic [3:0] sa, sb;
        @(negedge clk);
        D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb; D_valC = vc; D_valP = vp;
        D_valid = vld; E_stall = st; E_bubble = bb;
        W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
        sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra : (ic inside {4'h9, 4'hB}) ? 4'd4 : RN;
        sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'd4 : RN;
        if (bb || (!st && !vld)) nx = bubble_val();
        else if (st) nx = m_e;
        else begin
            nx.icode = ic; nx.ifun = fn; nx.valC = vc;
            nx.valA  = (ic == 4'h7 || ic == 4'h8) ? vp : m_read(sa, de, ve, dm, vm);
            nx.valB  = m_read(sb, de, ve, dm, vm);
            nx.srcA  = sa; nx.srcB = sb;
            nx.dstE  = (ic inside {4'h2, 4'h3, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'd4 : RN;
            nx.dstM  = (ic inside {4'h5, 4'hB}) ? ra : RN;
            nx.valid = 1'b1;
        end
        exp_q.push_back(nx);
        m_e = nx;
        if (reg_ok(de)) m_regs[de] = ve;
        if (reg_ok(dm)) m_regs[dm] = vm;
        @(posedge clk);
        #1;
    endtask

    task automatic nop_wb(input logic [3:0] de, input logic [63:0] ve);
        drive(4'h1, 4'h0, RN, RN, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, de, ve, RN, 64'd0);
    endtask

    // scoreboard monitor: compares the D/E register after every capturing edge
    initial begin
        e_t got, exp;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = dut_e();
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL de_reg act=%h exp=%h", got, exp);
                end
            end
        end
    end

    initial begin
        logic [3:0]  ic, ra, rb, de, dm;
        logic [63:0] ve, vm;
        rst = 1'b1;
        D_icode = 4'h1; D_ifun = 4'h0; D_rA = RN; D_rB = RN; D_valC = '0; D_valP = '0;
        D_valid = 1'b0; E_stall = 1'b0; E_bubble = 1'b0;
        W_dstE = RN; W_dstM = RN; W_valE = '0; W_valM = '0; dbg_sel = 4'd0;
        model_reset();
        #1;
        chk("reset_E", 64'(dut_e() == bubble_val()), 64'd1);
        chk("reset_E_icode", 64'(E_icode), 64'h1);
        chk("reset_E_dstE", 64'(E_dstE), 64'hF);
        chk_dbg(4'd4);
        chk("reset_rsp", dbg_data, 64'h100);
        chk_dbg(4'd0);
        #10 rst = 1'b0;

        // bypass: rrmovq %r3,%r1 while W writes r3=55
        drive(4'h2, 4'h0, 4'd3, 4'd1, 64'd0, 64'd2, 1'b1, 1'b0, 1'b0, 4'd3, 64'd55, RN, 64'd0);
        chk("byp_valA", E_valA, 64'd55);
        chk("byp_srcA", 64'(E_srcA), 64'd3);
        chk("byp_dstE", 64'(E_dstE), 64'd1);
        drive(4'h2, 4'h0, 4'd3, 4'd6, 64'd0, 64'd4, 1'b1, 1'b0, 1'b0, RN, 64'd0, RN, 64'd0);
        chk("r3_later", E_valA, 64'd55);

        // pushq %r2 with r2=7, rsp=0x100
        nop_wb(4'd2, 64'd7);
        drive(4'hA, 4'h0, 4'd2, RN, 64'd0, 64'd10, 1'b1, 1'b0, 1'b0, RN, 64'd0, RN, 64'd0);
        chk("push_valA", E_valA, 64'd7);
        chk("push_valB", E_valB, 64'h100);
        chk("push_srcB", 64'(E_srcB), 64'd4);
        chk("push_dstM", 64'(E_dstM), 64'hF);

        // write-port conflict on r4: M wins both the bypass and the array write
        drive(4'h6, 4'h0, 4'd0, 4'd4, 64'd0, 64'd2, 1'b1, 1'b0, 1'b0, 4'd4, 64'd8, 4'd4, 64'd9);
        chk("conf_valB", E_valB, 64'd9);
        chk_dbg(4'd4);
        chk("conf_r4", dbg_data, 64'd9);

        // stall / bubble / load with a call
        drive(4'h3, 4'h0, RN, 4'd5, 64'h77, 64'h0A, 1'b1, 1'b0, 1'b0, RN, 64'd0, RN, 64'd0);
        drive(4'h8, 4'h0, RN, RN, 64'h40, 64'h1D, 1'b1, 1'b1, 1'b0, RN, 64'd0, RN, 64'd0);
        chk("stall_icode", 64'(E_icode), 64'h3);
        chk("stall_valC", E_valC, 64'h77);
        drive(4'h8, 4'h0, RN, RN, 64'h40, 64'h1D, 1'b1, 1'b1, 1'b1, RN, 64'd0, RN, 64'd0);
        chk("bubble_icode", 64'(E_icode), 64'h1);
        chk("bubble_valid", 64'(E_valid), 64'd0);
        drive(4'h8, 4'h0, RN, RN, 64'h40, 64'h1D, 1'b1, 1'b0, 1'b0, RN, 64'd0, RN, 64'd0);
        chk("call_valA", E_valA, 64'h1D);
        chk("call_dstE", 64'(E_dstE), 64'd4);

        // random traffic, write targets biased toward low IDs to force bypass hits
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #2 rst = 1'b1;
                #1;
                chk("midrst_valid", 64'(E_valid), 64'd0);
                chk("midrst_E", 64'(dut_e() == bubble_val()), 64'd1);
                model_reset();
                for (int r = 0; r < NREG; r++) chk_dbg(4'(r));
                @(negedge clk);
                rst = 1'b0;
            end
            ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            de = ($urandom_range(0, 3) == 0) ? RN : 4'($urandom_range(0, 7));
            dm = ($urandom_range(0, 2) == 0) ? RN : 4'($urandom_range(0, 7));
            ve = {$urandom, $urandom};
            vm = {$urandom, $urandom};
            drive(ic, 4'($urandom_range(0, 15)), ra, rb, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                  de, ve, dm, vm);
            if (n % 8 == 0) chk_dbg(4'($urandom_range(0, 15)));
        end

        repeat (10) if (exp_q.size() > 0) @(posedge clk);
        #3;
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
